// File: rtl/axi4_wr_responder_addr_step_if.sv
// AXI4 interface carrying the write channels plus the read-channel handshake
// outputs that this write-only responder holds inactive.
interface axi_inf #(
   parameter int DSIZE = 128
) ();
   logic [3:0]         awid;
   logic [31:0]        awaddr;
   logic [7:0]         awlen;
   logic [1:0]         awburst;
   logic               awvalid;
   logic               awready;
   logic [DSIZE-1:0]   wdata;
   logic [DSIZE/8-1:0] wstrb;
   logic               wlast;
   logic               wvalid;
   logic               wready;
   logic [3:0]         bid;
   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;
   logic               arready;
   logic               rvalid;

   modport slaver (
      input  awid, awaddr, awlen, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid,
      input  bready,
      output awready, wready, bid, bresp, bvalid,
      output arready, rvalid
   );
endinterface

// File: rtl/axi4_wr_responder_addr_step.sv
// AXI4 write responder: one burst at a time, each W beat written straight to a
// word-addressed memory in the handshake cycle; AXI addresses are scaled down by SLAVER_ADDR_STEP.
module axi4_wr_responder_addr_step #(
   parameter int SLAVER_ADDR_STEP = 8,
   parameter int MEM_ASIZE        = 16,
   parameter int DSIZE            = 128
) (
   input  logic                 clock,
   input  logic                 rst_n,
   axi_inf.slaver               slaver_inf,
   output logic                 mem_we,
   output logic [MEM_ASIZE-1:0] mem_addr,
   output logic [DSIZE-1:0]     mem_wdata,
   output logic [DSIZE/8-1:0]   mem_wstrb,
   input  logic                 mem_ready
);
   localparam int STEP_SHIFT = $clog2(SLAVER_ADDR_STEP);

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t               state_q, state_d;
   logic [3:0]           id_q, id_d;
   logic [7:0]           len_q, len_d;
   logic [1:0]           burst_q, burst_d;
   logic [MEM_ASIZE-1:0] addr_q, addr_d;
   logic [7:0]           beat_q, beat_d;
   logic                 err_q, err_d;
   logic                 beat_hs;
   logic                 burst_end;

   assign beat_hs   = (state_q == DATA) && slaver_inf.wvalid && mem_ready;
   assign burst_end = (beat_q == len_q) || slaver_inf.wlast;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         id_q    <= '0;
         len_q   <= '0;
         burst_q <= '0;
         addr_q  <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         len_q   <= len_d;
         burst_q <= burst_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      len_d   = len_q;
      burst_d = burst_q;
      addr_d  = addr_q;
      beat_d  = beat_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (slaver_inf.awvalid) begin
               id_d    = slaver_inf.awid;
               len_d   = slaver_inf.awlen;
               burst_d = slaver_inf.awburst;
               addr_d  = MEM_ASIZE'(slaver_inf.awaddr >> STEP_SHIFT);
               beat_d  = '0;
               // WRAP and reserved bursts are drained without writing
               err_d   = slaver_inf.awburst[1];
               state_d = DATA;
            end
         end
         DATA: begin
            if (beat_hs) begin
               beat_d = beat_q + 8'd1;
               if (burst_q != 2'b00) addr_d = addr_q + 1'b1;
               // wlast must coincide exactly with the awlen-th beat
               if (slaver_inf.wlast != (beat_q == len_q)) err_d = 1'b1;
               if (burst_end) state_d = RESP;
            end
         end
         RESP: begin
            if (slaver_inf.bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      slaver_inf.awready = 1'b0;
      slaver_inf.wready  = 1'b0;
      slaver_inf.bvalid  = 1'b0;
      slaver_inf.bid     = id_q;
      slaver_inf.bresp   = 2'b00;
      slaver_inf.arready = 1'b0;
      slaver_inf.rvalid  = 1'b0;
      mem_we             = 1'b0;
      mem_addr           = '0;
      mem_wdata          = '0;
      mem_wstrb          = '0;
      unique case (state_q)
         IDLE: slaver_inf.awready = 1'b1;
         DATA: begin
            slaver_inf.wready = mem_ready;
            mem_we            = beat_hs && !err_q;
            mem_addr          = addr_q;
            mem_wdata         = slaver_inf.wdata;
            mem_wstrb         = slaver_inf.wstrb;
         end
         RESP: begin
            slaver_inf.bvalid = 1'b1;
            slaver_inf.bresp  = err_q ? 2'b10 : 2'b00;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_axi4_wr_responder_addr_step.sv
// Directed bench for axi4_wr_responder_addr_step with hand-computed expectations.
module tb_axi4_wr_responder_addr_step;
   localparam int DSIZE = 128;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         mem_ready = 1'b0;
   logic         mem_we;
   logic [15:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [15:0]  mem_wstrb;
   int           n_tests = 0;
   int           n_fail = 0;
   bit           tog = 1'b0;

   axi_inf #(.DSIZE(DSIZE)) axi ();

   axi4_wr_responder_addr_step #(
      .SLAVER_ADDR_STEP(8),
      .MEM_ASIZE(16),
      .DSIZE(DSIZE)
   ) dut (
      .clock(clk),
      .rst_n(rst_n),
      .slaver_inf(axi),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
      axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awburst = burst;
      axi.awvalid = 1'b1;
      #1;
      chk("aw_awready", axi.awready, 1'b1);
      chk("aw_wready_idle", axi.wready, 1'b0);
      step();
      axi.awvalid = 1'b0;
      #1;
      chk("aw_awready_busy", axi.awready, 1'b0);
   endtask

   // mem_ready is bench-driven, so each beat completes within two cycles
   task automatic send_beat(input string tag, input logic [127:0] d, input logic [15:0] s,
                            input bit last, input bit exp_we, input logic [15:0] exp_addr);
      bit done = 1'b0;
      axi.wdata = d; axi.wstrb = s; axi.wlast = last; axi.wvalid = 1'b1;
      for (int c = 0; c < 4 && !done; c++) begin
         mem_ready = tog ? ~mem_ready : 1'b1;
         #1;
         chk({tag, "_wready"}, axi.wready, mem_ready);
         chk({tag, "_we"}, mem_we, mem_ready & exp_we);
         if (mem_ready) begin
            done = 1'b1;
            if (exp_we) begin
               chk({tag, "_addr"}, mem_addr, exp_addr);
               chk({tag, "_wdata"}, mem_wdata, d);
               chk({tag, "_wstrb"}, mem_wstrb, s);
            end
         end
         step();
      end
      if (!done) chk({tag, "_beat_done"}, 1'b0, 1'b1);
      axi.wvalid = 1'b0;
   endtask

   task automatic finish_b(input string tag, input logic [3:0] exp_id,
                           input logic [1:0] exp_resp, input int hold);
      axi.wvalid = 1'b1; axi.wlast = 1'b1; mem_ready = 1'b1;
      for (int h = 0; h <= hold; h++) begin
         axi.bready = (h == hold);
         #1;
         chk({tag, "_bvalid"}, axi.bvalid, 1'b1);
         chk({tag, "_bid"}, axi.bid, exp_id);
         chk({tag, "_bresp"}, axi.bresp, exp_resp);
         chk({tag, "_awready_resp"}, axi.awready, 1'b0);
         chk({tag, "_wready_resp"}, axi.wready, 1'b0);
         chk({tag, "_we_resp"}, mem_we, 1'b0);
         step();
      end
      axi.bready = 1'b0; axi.wvalid = 1'b0; axi.wlast = 1'b0;
      #1;
      chk({tag, "_bvalid_done"}, axi.bvalid, 1'b0);
      chk({tag, "_awready_back"}, axi.awready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awburst = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      #3;
      chk("rst_awready", axi.awready, 1'b1);
      chk("rst_wready", axi.wready, 1'b0);
      chk("rst_bvalid", axi.bvalid, 1'b0);
      chk("rst_bresp", axi.bresp, 2'b00);
      chk("rst_bid", axi.bid, 4'd0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_arready", axi.arready, 1'b0);
      chk("rst_rvalid", axi.rvalid, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      // single beat: 0x40 / 8 = 8
      send_aw(4'd3, 32'h40, 8'd0, 2'b01);
      send_beat("single", 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_1111, 16'hFFFF, 1'b1, 1'b1, 16'h0008);
      finish_b("single", 4'd3, 2'b00, 0);

      // INCR 0x100 -> 0x20..0x23 with mem_ready toggling
      tog = 1'b1; mem_ready = 1'b1;
      send_aw(4'd5, 32'h100, 8'd3, 2'b01);
      send_beat("incr0", 128'h10, 16'h0001, 1'b0, 1'b1, 16'h0020);
      send_beat("incr1", 128'h11, 16'h0003, 1'b0, 1'b1, 16'h0021);
      send_beat("incr2", 128'h12, 16'h0007, 1'b0, 1'b1, 16'h0022);
      send_beat("incr3", 128'h13, 16'h000F, 1'b1, 1'b1, 16'h0023);
      tog = 1'b0;
      finish_b("incr", 4'd5, 2'b00, 0);

      // FIXED: all three beats at 0x80 / 8 = 0x10
      send_aw(4'd1, 32'h80, 8'd2, 2'b00);
      send_beat("fixed0", 128'hA0, 16'h00F0, 1'b0, 1'b1, 16'h0010);
      send_beat("fixed1", 128'hA1, 16'h0F0F, 1'b0, 1'b1, 16'h0010);
      send_beat("fixed2", 128'hA2, 16'h8001, 1'b1, 1'b1, 16'h0010);
      finish_b("fixed", 4'd1, 2'b00, 0);

      // early wlast on beat 1 of a 4-beat burst
      send_aw(4'd6, 32'h200, 8'd3, 2'b01);
      send_beat("early0", 128'hB0, 16'hFFFF, 1'b0, 1'b1, 16'h0040);
      send_beat("early1", 128'hB1, 16'hFFFF, 1'b1, 1'b1, 16'h0041);
      finish_b("early", 4'd6, 2'b10, 0);

      // missing wlast on the only beat
      send_aw(4'd11, 32'h10, 8'd0, 2'b01);
      send_beat("miss0", 128'hC0, 16'hFFFF, 1'b0, 1'b1, 16'h0002);
      finish_b("miss", 4'd11, 2'b10, 0);

      // WRAP and reserved bursts are consumed but never written
      send_aw(4'd9, 32'h300, 8'd1, 2'b10);
      send_beat("wrap0", 128'hD0, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
      send_beat("wrap1", 128'hD1, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
      finish_b("wrap", 4'd9, 2'b10, 0);
      send_aw(4'd10, 32'h308, 8'd0, 2'b11);
      send_beat("rsvd0", 128'hD2, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
      finish_b("rsvd", 4'd10, 2'b10, 1);

      // address wrap at the top of memory, then B backpressure for 5 cycles
      send_aw(4'd4, 32'h0007_FFF8, 8'd1, 2'b01);
      send_beat("bound0", 128'hE0, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF);
      send_beat("bound1", 128'hE1, 16'hFFFF, 1'b1, 1'b1, 16'h0000);
      finish_b("bound", 4'd4, 2'b00, 5);

      // reset during beat 2 of a 4-beat burst
      send_aw(4'd2, 32'h40, 8'd3, 2'b01);
      send_beat("rst0", 128'hF0, 16'hFFFF, 1'b0, 1'b1, 16'h0008);
      send_beat("rst1", 128'hF1, 16'hFFFF, 1'b0, 1'b1, 16'h0009);
      axi.wdata = 128'hF2; axi.wstrb = 16'hFFFF; axi.wlast = 1'b0; axi.wvalid = 1'b1; mem_ready = 1'b1;
      #1;
      chk("rst2_we_before", mem_we, 1'b1);
      chk("rst2_addr_before", mem_addr, 16'h000A);
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_we", mem_we, 1'b0);
      chk("midrst_wready", axi.wready, 1'b0);
      chk("midrst_awready", axi.awready, 1'b1);
      chk("midrst_bvalid", axi.bvalid, 1'b0);
      chk("midrst_bid", axi.bid, 4'd0);
      chk("midrst_mem_addr", mem_addr, 16'h0000);
      axi.wvalid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("postrst_bvalid", axi.bvalid, 1'b0);
         chk("postrst_awready", axi.awready, 1'b1);
         step();
      end
      send_aw(4'd7, 32'h48, 8'd0, 2'b01);
      send_beat("after_rst", 128'h77, 16'h00FF, 1'b1, 1'b1, 16'h0009);
      finish_b("after_rst", 4'd7, 2'b00, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axi4_wr_responder_addr_step.md
AXI4_WR_RESPONDER_ADDR_STEP -- requirements
Module: axi4_wr_responder_addr_step

Interface
REQ-001 Parameter SLAVER_ADDR_STEP, default 8: AXI address units per data beat; power of two.
REQ-002 Parameter MEM_ASIZE, default 16: memory word-address width.
REQ-003 Parameter DSIZE, default 128: data width; must equal slaver_inf.DSIZE.
REQ-004 Port clock, input, 1: the single clock for all logic.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port slaver_inf, axi_inf.slaver, -: AXI4 write channels (AW/W/B); read channels unused, arready=0, rvalid=0.
REQ-007 Port mem_we, output, 1: memory write strobe for one word.
REQ-008 Port mem_addr, output, MEM_ASIZE: memory word address.
REQ-009 Port mem_wdata, output, DSIZE: write data.
REQ-010 Port mem_wstrb, output, DSIZE/8: byte enables.
REQ-011 Port mem_ready, input, 1: memory accepts a write this cycle.

Function
REQ-012 FSM states: IDLE, DATA, RESP; exactly one burst is outstanding at a time.
REQ-013 IDLE: awready=1, wready=0, bvalid=0; on awvalid&awready, latch awid, awlen and awburst; load addr_cnt = awaddr / SLAVER_ADDR_STEP, truncated to MEM_ASIZE; clear beat_cnt; clear err; go to DATA.
REQ-014 awburst WRAP (2'b10) or reserved (2'b11) at acceptance: set err; data is still consumed but mem_we is held 0 for the whole burst.
REQ-015 DATA: awready=0, wready=mem_ready; beat handshake = wvalid&wready.
REQ-016 mem_we = beat handshake & !err, combinational, so the memory write happens in the same cycle as the W handshake (zero latency).
REQ-017 mem_addr=addr_cnt, mem_wdata=wdata, mem_wstrb=wstrb, driven combinationally in DATA.
REQ-018 On each beat: INCR increments addr_cnt by 1, modulo 2^MEM_ASIZE (wraps silently); FIXED holds addr_cnt; beat_cnt increments by 1.
REQ-019 Burst ends on the beat where beat_cnt==awlen or wlast=1, whichever comes first; next state is RESP.
REQ-020 Set err if wlast=1 with beat_cnt<awlen (early last) or wlast=0 with beat_cnt==awlen (missing last); beats after the burst end are not accepted in DATA.
REQ-021 RESP: bvalid=1, bid=latched awid, bresp=2'b10 (SLVERR) if err else 2'b00 (OKAY); on bready go to IDLE; bvalid, bid and bresp stay stable until the handshake.
REQ-022 bvalid rises the cycle after the final beat handshake; awready returns the cycle after the B handshake.
REQ-023 awlen=0: a single beat, which is also the final beat.
REQ-024 mem_ready=0 in DATA stalls the burst with no state change; wvalid=0 does the same.
REQ-025 When not in DATA: mem_we=0 and wready=0.

Reset
REQ-026 rst_n=0 forces IDLE asynchronously: awready=1 after reset, and wready=0, bvalid=0, bresp=0, bid=0, mem_we=0, addr_cnt=0, beat_cnt=0, err=0.
REQ-027 Reset mid-burst or in RESP abandons the burst; no B response is issued for it; the first AW after release is accepted normally.

Verification
REQ-028 Single beat: awaddr=0x40, awlen=0, INCR, awid=3, wlast=1 -> mem_we for one cycle at mem_addr=8; bvalid with bid=3, bresp=OKAY one cycle later.
REQ-029 INCR burst: awaddr=0x100, awlen=3, mem_ready toggling every other cycle -> 4 writes to addresses 0x20..0x23, in order, only on mem_ready=1 cycles; bresp=OKAY.
REQ-030 FIXED burst: awlen=2 -> 3 writes, all at the same mem_addr; wstrb is passed through unchanged.
REQ-031 Protocol errors: awlen=3 with wlast on beat 1 -> burst ends after 2 beats with bresp=SLVERR; a separate WRAP burst -> no mem_we and bresp=SLVERR.
REQ-032 Boundary and backpressure: INCR burst starting at mem_addr=2^MEM_ASIZE-1 with awlen=1 -> second write goes to address 0. bready held 0 for 5 cycles -> bvalid/bid/bresp stable and awready=0 throughout.
REQ-033 Reset: rst_n pulsed low during beat 2 of a 4-beat burst -> outputs return to their reset values immediately and no bvalid follows; the next burst completes with OKAY.
